// File: rtl/demux_1_to_n_buffered.sv
// Registered 1-to-N demultiplexer with one valid/ready output slot per channel.
// Routes the producer stream to the channel picked by select, or to every
// channel at once when broadcast is set (all-or-nothing).
module demux_1_to_n_buffered #(
  parameter int unsigned bits     = 16,
  parameter int unsigned sel_bits = 2
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [bits-1:0]               in,
  input  logic [sel_bits-1:0]           select,
  input  logic                          broadcast,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [bits*(2**sel_bits)-1:0] out,
  output logic [(2**sel_bits)-1:0]      out_valid,
  input  logic [(2**sel_bits)-1:0]      out_ready
);

  localparam int unsigned N = 2 ** sel_bits;

  logic [N-1:0]    full_q;
  logic [N-1:0]    full_d;
  logic [bits-1:0] data_q [N];
  logic [bits-1:0] data_d [N];

  logic [N-1:0]    can_take;
  logic [N-1:0]    target;
  logic            accept;

  // Acceptance: a slot can take data if empty or draining this cycle
  always_comb begin
    can_take = ~full_q | out_ready;
    target   = broadcast ? {N{1'b1}} : (N'(1) << select);
    in_ready = broadcast ? (&can_take) : can_take[select];
    accept   = in_valid & in_ready;
  end

  // Next-state per channel: refill wins over drain, otherwise hold
  always_comb begin
    full_d = full_q;
    for (int unsigned k = 0; k < N; k++) begin
      data_d[k] = data_q[k];
      if (accept && target[k]) begin
        data_d[k] = in;
        full_d[k] = 1'b1;
      end else if (full_q[k] && out_ready[k]) begin
        full_d[k] = 1'b0;
      end
    end
  end

  // Slot state and data registers, cleared asynchronously
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      full_q <= '0;
      for (int unsigned k = 0; k < N; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      full_q <= full_d;
      for (int unsigned k = 0; k < N; k++) begin
        data_q[k] <= data_d[k];
      end
    end
  end

  // Present the slot registers on the flat output bus
  always_comb begin
    out_valid = full_q;
    out       = '0;
    for (int unsigned k = 0; k < N; k++) begin
      out[bits*k +: bits] = data_q[k];
    end
  end

endmodule

// File: tb/tb_demux_1_to_n_buffered.sv
// Directed bench for demux_1_to_n_buffered (bits=16, 4 channels).
module tb_demux_1_to_n_buffered;

  logic        clock;
  logic        reset;
  logic [15:0] in;
  logic [1:0]  select;
  logic        broadcast;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] out;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;

  int n_cmp;
  int n_err;

  demux_1_to_n_buffered #(.bits(16), .sel_bits(2)) dut (
    .clock     (clock),
    .reset     (reset),
    .in        (in),
    .select    (select),
    .broadcast (broadcast),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [63:0] route_exp [4];
    logic [15:0] route_dat [4];
    n_cmp     = 0;
    n_err     = 0;
    reset     = 1'b1;
    in        = '0;
    select    = '0;
    broadcast = 1'b0;
    in_valid  = 1'b0;
    out_ready = 4'b0000;
    route_dat[0] = 16'h1111; route_dat[1] = 16'h2222;
    route_dat[2] = 16'h3333; route_dat[3] = 16'h4444;
    route_exp[0] = 64'h0000_0000_0000_1111;
    route_exp[1] = 64'h0000_0000_2222_1111;
    route_exp[2] = 64'h0000_3333_2222_1111;
    route_exp[3] = 64'h4444_3333_2222_1111;

    step();
    step();
    reset = 1'b0;

    // Load channel 2 with 0xBEEF, then reset asynchronously mid-cycle
    select   = 2'd2;
    in       = 16'hBEEF;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("pre_reset_valid", 64'(out_valid), 64'h4);
    check("pre_reset_data", 64'(out[47:32]), 64'hBEEF);
    #2 reset = 1'b1;
    #1;
    check("reset_valid", 64'(out_valid), 64'h0);
    check("reset_out", out, 64'h0);
    check("reset_in_ready", 64'(in_ready), 64'h1);
    step();
    reset = 1'b0;

    // Routing to each channel in turn with all consumers ready
    out_ready = 4'b1111;
    in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      select = 2'(i);
      in     = route_dat[i];
      #1;
      check($sformatf("route_ready_%0d", i), 64'(in_ready), 64'h1);
      step();
      check($sformatf("route_valid_%0d", i), 64'(out_valid), 64'(4'b0001 << i));
      check($sformatf("route_out_%0d", i), out, route_exp[i]);
    end
    in_valid = 1'b0;
    step();
    check("route_drained", 64'(out_valid), 64'h0);

    // Backpressure on channel 1
    out_ready = 4'b1101;
    select    = 2'd1;
    in        = 16'hAAAA;
    in_valid  = 1'b1;
    step();
    check("bp_first_valid", 64'(out_valid), 64'h2);
    check("bp_first_data", 64'(out[31:16]), 64'hAAAA);
    in = 16'hBBBB;
    #1;
    check("bp_blocked_ready", 64'(in_ready), 64'h0);
    step();
    check("bp_hold_valid", 64'(out_valid), 64'h2);
    check("bp_hold_data", 64'(out[31:16]), 64'hAAAA);

    // Independence: channel 3 still accepts while channel 1 is stalled
    select = 2'd3;
    in     = 16'h5555;
    #1;
    check("indep_ready", 64'(in_ready), 64'h1);
    step();
    check("indep_valid", 64'(out_valid), 64'hA);
    check("indep_data", 64'(out[63:48]), 64'h5555);
    check("indep_ch1_kept", 64'(out[31:16]), 64'hAAAA);

    // Release channel 1; 0xBBBB delivered once
    select = 2'd1;
    in     = 16'hBBBB;
    #1;
    check("bp_still_blocked", 64'(in_ready), 64'h0);
    out_ready = 4'b1111;
    #1;
    check("bp_release_ready", 64'(in_ready), 64'h1);
    step();
    in_valid = 1'b0;
    check("bp_second_valid", 64'(out_valid), 64'h2);
    check("bp_second_data", 64'(out[31:16]), 64'hBBBB);
    step();
    check("bp_no_dup", 64'(out_valid), 64'h0);

    // Broadcast blocked by stalled channel 0, then released
    out_ready = 4'b1110;
    select    = 2'd0;
    in        = 16'h0F0F;
    in_valid  = 1'b1;
    step();
    check("bc_fill_valid", 64'(out_valid), 64'h1);
    broadcast = 1'b1;
    in        = 16'hC0DE;
    #1;
    check("bc_blocked_ready", 64'(in_ready), 64'h0);
    step();
    check("bc_blocked_valid", 64'(out_valid), 64'h1);
    check("bc_blocked_out", out, 64'h5555_3333_BBBB_0F0F);
    out_ready = 4'b1111;
    #1;
    check("bc_release_ready", 64'(in_ready), 64'h1);
    step();
    in_valid  = 1'b0;
    broadcast = 1'b0;
    check("bc_all_valid", 64'(out_valid), 64'hF);
    check("bc_all_out", out, 64'hC0DE_C0DE_C0DE_C0DE);
    step();
    check("bc_drained", 64'(out_valid), 64'h0);

    // Drain and refill in the same cycle on channel 2
    out_ready = 4'b0000;
    select    = 2'd2;
    in        = 16'h0001;
    in_valid  = 1'b1;
    step();
    check("dr_first_valid", 64'(out_valid), 64'h4);
    check("dr_first_data", 64'(out[47:32]), 64'h0001);
    out_ready = 4'b0100;
    in        = 16'h0002;
    #1;
    check("dr_ready", 64'(in_ready), 64'h1);
    step();
    in_valid = 1'b0;
    check("dr_refill_valid", 64'(out_valid), 64'h4);
    check("dr_refill_data", 64'(out[47:32]), 64'h0002);
    step();
    check("dr_drained", 64'(out_valid), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
